ext_bus_bridge: RTL and testbench

- Synchronous, parametrised bridge from the MCU multiplexed external bus (AE, EXT_READ, EXT_WRITE, EXT_AD_OUT/EXT_AD_IN, EXT_READY) to NUM_REGIONS demultiplexed slave ports.
- Assembles the multi-beat address from the narrow AD bus and captures write data.
- Decodes the address into per-region strobes with a base/mask table.
- Returns read data and ready. Unmapped addresses and hung slaves complete with an error instead of stalling the core.

---
 rtl/ext_bus_pkg.sv | 31 +++
 rtl/ext_bus_addr_decoder.sv | 26 ++
 rtl/ext_bus_bridge.sv | 183 ++++++++++++++++++
 tb/tb_ext_bus_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and elaboration helpers for the multiplexed external bus bridge.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LATCHED = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_RESP    = 3'd4
  } ext_bus_state_t;

  // Number of AD beats needed to carry one full address.
  function automatic int calc_beats(input int addr_w, input int ad_w);
    return addr_w / ad_w;
  endfunction

  // Counter width helper that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

  // Legal parameter combination check used at elaboration.
  function automatic bit params_ok(input int ad_w, input int addr_w, input int data_w,
                                   input int num_regions, input int timeout);
    return (ad_w >= 1) && (addr_w >= ad_w) && ((addr_w % ad_w) == 0) &&
           (data_w >= 1) && (data_w <= ad_w) && (num_regions >= 1) && (timeout >= 1);
  endfunction

endpackage

// File: rtl/ext_bus_addr_decoder.sv
// Combinational base/mask region decoder; lowest matching region wins.
module ext_bus_addr_decoder
  import ext_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h0000_1000, 32'h1A10_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFF_F000, 32'hFFFE_0000}
) (
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic [NUM_REGIONS-1:0] o_hit,
  output logic                   o_miss
);

  logic [NUM_REGIONS-1:0] w_raw_hit;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    assign w_raw_hit[i] = ((i_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                           REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // Keep only the lowest set bit so overlapping regions resolve by index.
  assign o_hit  = w_raw_hit & (~w_raw_hit + NUM_REGIONS'(1));
  assign o_miss = ~(|w_raw_hit);

endmodule

// File: rtl/ext_bus_bridge.sv
// Bridge from the MCU multiplexed AD bus to demultiplexed, region-decoded slave ports.
module ext_bus_bridge
  import ext_bus_pkg::*;
#(
  parameter int AD_WIDTH       = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REGIONS    = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h0000_1000, 32'h1A10_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFF_F000, 32'hFFFE_0000},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ae,
  input  logic                              ext_read,
  input  logic                              ext_write,
  input  logic [AD_WIDTH-1:0]               ext_ad_out,
  output logic [DATA_WIDTH-1:0]             ext_ad_in,
  output logic                              ext_ready,
  output logic [ADDR_WIDTH-1:0]             dev_addr,
  output logic [DATA_WIDTH-1:0]             dev_wdata,
  output logic [NUM_REGIONS-1:0]            dev_read,
  output logic [NUM_REGIONS-1:0]            dev_write,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] dev_rdata,
  input  logic [NUM_REGIONS-1:0]            dev_ready,
  output logic                              bus_err
);

  localparam int BEATS = calc_beats(ADDR_WIDTH, AD_WIDTH);
  localparam int BC_W  = clog2_min1(BEATS + 1);
  localparam int TO_W  = clog2_min1(TIMEOUT_CYCLES);

  if (!params_ok(AD_WIDTH, ADDR_WIDTH, DATA_WIDTH, NUM_REGIONS, TIMEOUT_CYCLES)) begin : g_bad_params
    $error("ext_bus_bridge: illegal parameter combination");
  end

  ext_bus_state_t          r_state;
  logic [BC_W-1:0]         r_beat_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic [ADDR_WIDTH-1:0]   r_dev_addr;
  logic [DATA_WIDTH-1:0]   r_dev_wdata;
  logic [NUM_REGIONS-1:0]  r_dev_read;
  logic [NUM_REGIONS-1:0]  r_dev_write;
  logic [DATA_WIDTH-1:0]   r_ext_ad_in;
  logic                    r_ext_ready;
  logic                    r_bus_err;

  logic [NUM_REGIONS-1:0]  w_hit;
  logic                    w_miss;
  logic [NUM_REGIONS-1:0]  w_sel;
  logic                    w_sel_ready;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;

  ext_bus_addr_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .i_addr (r_dev_addr),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  // The active strobe identifies the selected slave; other readies are ignored.
  assign w_sel       = r_dev_read | r_dev_write;
  assign w_sel_ready = |(dev_ready & w_sel);

  // Read data mux for the selected region (strobe is one-hot).
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_sel_rdata = w_sel_rdata | (dev_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_sel[i]}});
    end
  end

  // Main FSM: address beat assembly, decode, slave access with timeout, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_to_cnt    <= '0;
      r_dev_addr  <= '0;
      r_dev_wdata <= '0;
      r_dev_read  <= '0;
      r_dev_write <= '0;
      r_ext_ad_in <= '0;
      r_ext_ready <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ae) begin
            r_dev_addr[AD_WIDTH-1:0] <= ext_ad_out;
            r_beat_cnt               <= BC_W'(1);
            r_state                  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ae) begin
            // Beats past the full address are dropped rather than wrapping.
            if (r_beat_cnt < BC_W'(BEATS)) begin
              for (int b = 1; b < BEATS; b++) begin
                if (r_beat_cnt == BC_W'(b)) r_dev_addr[b*AD_WIDTH +: AD_WIDTH] <= ext_ad_out;
              end
              r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
          end else if (r_beat_cnt == BC_W'(BEATS)) begin
            r_dev_wdata <= ext_ad_out[DATA_WIDTH-1:0];
            r_state     <= ST_LATCHED;
          end else begin
            r_bus_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_LATCHED: begin
          if (ae) begin
            r_dev_addr[AD_WIDTH-1:0] <= ext_ad_out;
            r_beat_cnt               <= BC_W'(1);
            r_state                  <= ST_ADDR;
          end else if (ext_read && ext_write) begin
            r_bus_err   <= 1'b1;
            r_ext_ad_in <= '0;
            r_ext_ready <= 1'b1;
            r_state     <= ST_RESP;
          end else if (ext_read || ext_write) begin
            if (w_miss) begin
              r_bus_err   <= 1'b1;
              r_ext_ad_in <= '0;
              r_ext_ready <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_dev_read  <= ext_read  ? w_hit : '0;
              r_dev_write <= ext_write ? w_hit : '0;
              r_to_cnt    <= '0;
              r_state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            // Writes return zero data to the core.
            r_ext_ad_in <= (|r_dev_read) ? w_sel_rdata : '0;
            r_ext_ready <= 1'b1;
            r_dev_read  <= '0;
            r_dev_write <= '0;
            r_state     <= ST_RESP;
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_bus_err   <= 1'b1;
            r_ext_ad_in <= '0;
            r_ext_ready <= 1'b1;
            r_dev_read  <= '0;
            r_dev_write <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_RESP: begin
          if (!ext_read && !ext_write) begin
            r_ext_ready <= 1'b0;
            r_ext_ad_in <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ext_ad_in = r_ext_ad_in;
  assign ext_ready = r_ext_ready;
  assign dev_addr  = r_dev_addr;
  assign dev_wdata = r_dev_wdata;
  assign dev_read  = r_dev_read;
  assign dev_write = r_dev_write;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed self-checking bench for ext_bus_bridge.
module tb_ext_bus_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ae;
  logic        ext_read;
  logic        ext_write;
  logic [15:0] ext_ad_out;
  logic [7:0]  ext_ad_in;
  logic        ext_ready;
  logic [31:0] dev_addr;
  logic [7:0]  dev_wdata;
  logic [1:0]  dev_read;
  logic [1:0]  dev_write;
  logic [15:0] dev_rdata;
  logic [1:0]  dev_ready;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  ext_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ae         (ae),
    .ext_read   (ext_read),
    .ext_write  (ext_write),
    .ext_ad_out (ext_ad_out),
    .ext_ad_in  (ext_ad_in),
    .ext_ready  (ext_ready),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_read   (dev_read),
    .dev_write  (dev_write),
    .dev_rdata  (dev_rdata),
    .dev_ready  (dev_ready),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two address beats (low half first) then the write-data / latch cycle.
  task automatic send_addr(input logic [31:0] a, input logic [7:0] wd);
    ae = 1'b1; ext_ad_out = a[15:0];  tick();
    ext_ad_out = a[31:16];            tick();
    ae = 1'b0; ext_ad_out = {8'h00, wd}; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ae = 1'b0; ext_read = 1'b0; ext_write = 1'b0;
    ext_ad_out = 16'h0000; dev_rdata = 16'h0000; dev_ready = 2'b00;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({ext_ready, bus_err, dev_read, dev_write} !== 6'b0 || dev_addr !== 32'h0 || ext_ad_in !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got rdy=%b err=%b rd=%b wr=%b addr=%h din=%h exp all zero",
                         ext_ready, bus_err, dev_read, dev_write, dev_addr, ext_ad_in);
    end
  endtask

  task automatic test_write_region0();
    send_addr(32'h1A10_0000, 8'h5A);
    checks++;
    if (dev_addr !== 32'h1A10_0000) begin errors++; $display("FAIL wr_addr got %h exp %h", dev_addr, 32'h1A10_0000); end
    checks++;
    if (dev_wdata !== 8'h5A) begin errors++; $display("FAIL wr_wdata got %h exp %h", dev_wdata, 8'h5A); end
    ext_write = 1'b1; tick();
    checks++;
    if (dev_write !== 2'b01 || dev_read !== 2'b00 || ext_ready !== 1'b0) begin
      errors++; $display("FAIL wr_strobe got wr=%b rd=%b rdy=%b exp wr=01 rd=00 rdy=0", dev_write, dev_read, ext_ready);
    end
    tick();
    checks++;
    if (dev_write !== 2'b01) begin errors++; $display("FAIL wr_strobe_hold got %b exp 01", dev_write); end
    dev_ready = 2'b01; dev_rdata = 16'hABCD; tick();
    dev_ready = 2'b00;
    checks++;
    if (dev_write !== 2'b00 || ext_ready !== 1'b1 || ext_ad_in !== 8'h00 || bus_err !== 1'b0) begin
      errors++; $display("FAIL wr_resp got wr=%b rdy=%b din=%h err=%b exp wr=00 rdy=1 din=00 err=0",
                         dev_write, ext_ready, ext_ad_in, bus_err);
    end
    tick();
    checks++;
    if (ext_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_hold got %b exp 1", ext_ready); end
    ext_write = 1'b0; tick();
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_drop got %b exp 0", ext_ready); end
  endtask

  task automatic test_read_region1();
    int strobe_cycles;
    strobe_cycles = 0;
    send_addr(32'h0000_1234, 8'h00);
    dev_rdata = {8'hC3, 8'hEE};
    ext_read = 1'b1; tick();
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %b exp 0", ext_ready); end
    for (int k = 0; k < 4; k++) begin
      if (dev_read === 2'b10) strobe_cycles++;
      // Ready from the non-selected region must be ignored.
      dev_ready = (k == 1) ? 2'b01 : ((k == 3) ? 2'b10 : 2'b00);
      tick();
    end
    dev_ready = 2'b00;
    checks++;
    if (strobe_cycles !== 4) begin errors++; $display("FAIL rd_strobe_cycles got %0d exp 4", strobe_cycles); end
    checks++;
    if (dev_read !== 2'b00 || ext_ready !== 1'b1 || ext_ad_in !== 8'hC3 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rd_resp got rd=%b rdy=%b din=%h err=%b exp rd=00 rdy=1 din=c3 err=0",
                         dev_read, ext_ready, ext_ad_in, bus_err);
    end
    ext_read = 1'b0; tick();
    checks++;
    if (ext_ready !== 1'b0 || ext_ad_in !== 8'h00) begin
      errors++; $display("FAIL rd_idle got rdy=%b din=%h exp rdy=0 din=00", ext_ready, ext_ad_in);
    end
  endtask

  task automatic test_decode_miss();
    send_addr(32'h0000_0040, 8'h00);
    dev_rdata = 16'hFFFF;
    ext_read = 1'b1; tick();
    checks++;
    if (bus_err !== 1'b1 || ext_ready !== 1'b1 || ext_ad_in !== 8'h00 || dev_read !== 2'b00) begin
      errors++; $display("FAIL miss_resp got err=%b rdy=%b din=%h rd=%b exp err=1 rdy=1 din=00 rd=00",
                         bus_err, ext_ready, ext_ad_in, dev_read);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL miss_err_pulse got %b exp 0", bus_err); end
    ext_read = 1'b0; tick();
  endtask

  task automatic test_extra_beats();
    ae = 1'b1; ext_ad_out = 16'h1000; tick();
    ext_ad_out = 16'h0000; tick();
    ext_ad_out = 16'hFFFF; tick();
    ae = 1'b0; ext_ad_out = 16'h0000; tick();
    checks++;
    if (dev_addr !== 32'h0000_1000 || bus_err !== 1'b0) begin
      errors++; $display("FAIL extra_beats got addr=%h err=%b exp addr=00001000 err=0", dev_addr, bus_err);
    end
  endtask

  task automatic test_timeout();
    int strobe_cycles;
    int guard;
    strobe_cycles = 0;
    guard = 0;
    send_addr(32'h1A10_0004, 8'h00);
    dev_rdata = 16'h5555; dev_ready = 2'b00;
    ext_read = 1'b1; tick();
    while (dev_read === 2'b01 && guard < 4 * TO) begin
      strobe_cycles++; guard++; tick();
    end
    checks++;
    if (strobe_cycles !== TO) begin errors++; $display("FAIL to_strobe_cycles got %0d exp %0d", strobe_cycles, TO); end
    checks++;
    if (bus_err !== 1'b1 || ext_ready !== 1'b1 || ext_ad_in !== 8'h00) begin
      errors++; $display("FAIL to_resp got err=%b rdy=%b din=%h exp err=1 rdy=1 din=00", bus_err, ext_ready, ext_ad_in);
    end
    ext_read = 1'b0; tick();
  endtask

  task automatic test_short_and_protocol();
    ae = 1'b1; ext_ad_out = 16'hBEEF; tick();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL short_no_early_err got %b exp 0", bus_err); end
    ae = 1'b0; ext_ad_out = 16'h0000; tick();
    checks++;
    if (bus_err !== 1'b1 || dev_addr !== 32'h1A10_BEEF) begin
      errors++; $display("FAIL short_err got err=%b addr=%h exp err=1 addr=1a10beef", bus_err, dev_addr);
    end
    // Back in IDLE a stray read must be ignored.
    ext_read = 1'b1; tick();
    checks++;
    if (bus_err !== 1'b0 || dev_read !== 2'b00 || ext_ready !== 1'b0) begin
      errors++; $display("FAIL short_idle got err=%b rd=%b rdy=%b exp 0 00 0", bus_err, dev_read, ext_ready);
    end
    ext_read = 1'b0;
    send_addr(32'h1A10_0000, 8'h00);
    ext_read = 1'b1; ext_write = 1'b1; tick();
    checks++;
    if (bus_err !== 1'b1 || ext_ready !== 1'b1 || dev_read !== 2'b00 || dev_write !== 2'b00 || ext_ad_in !== 8'h00) begin
      errors++; $display("FAIL rw_conflict got err=%b rdy=%b rd=%b wr=%b din=%h exp 1 1 00 00 00",
                         bus_err, ext_ready, dev_read, dev_write, ext_ad_in);
    end
    ext_read = 1'b0; ext_write = 1'b0; tick();
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL rw_conflict_drop got %b exp 0", ext_ready); end
  endtask

  task automatic test_reset_mid_access();
    send_addr(32'h1A10_0000, 8'h00);
    ext_read = 1'b1; tick();
    checks++;
    if (dev_read !== 2'b01) begin errors++; $display("FAIL mid_rd_strobe got %b exp 01", dev_read); end
    rst = 1'b1; tick();
    rst = 1'b0; ext_read = 1'b0;
    checks++;
    if (dev_read !== 2'b00 || dev_write !== 2'b00 || ext_ready !== 1'b0 || dev_addr !== 32'h0) begin
      errors++; $display("FAIL mid_reset got rd=%b wr=%b rdy=%b addr=%h exp all zero", dev_read, dev_write, ext_ready, dev_addr);
    end
    send_addr(32'h0000_1FFF, 8'h77);
    dev_ready = 2'b10;
    ext_write = 1'b1; tick();
    checks++;
    if (dev_write !== 2'b10 || dev_wdata !== 8'h77) begin
      errors++; $display("FAIL post_reset_wr got wr=%b wd=%h exp 10 77", dev_write, dev_wdata);
    end
    tick();
    checks++;
    if (ext_ready !== 1'b1 || dev_write !== 2'b00 || bus_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_resp got rdy=%b wr=%b err=%b exp 1 00 0", ext_ready, dev_write, bus_err);
    end
    dev_ready = 2'b00; ext_write = 1'b0; tick();
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0", ext_ready); end
  endtask

  initial begin
    test_reset();
    test_write_region0();
    test_read_region1();
    test_decode_miss();
    test_extra_beats();
    test_timeout();
    test_short_and_protocol();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
